// File: rtl/div16by8_seq_pkg.sv
// Shared constants, FSM state encoding and result payload for the sequential
// 16-by-8 restoring divider.
package div16by8_seq_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 8;
  localparam int unsigned CW = 4;

  localparam logic [DW-1:0] DIV_ZERO_QUOTIENT = 16'hFFFF;
  localparam logic [CW-1:0] LAST_STEP         = 4'd15;
  localparam logic [CW-1:0] ZDIV_LAST         = 4'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZDIV = 2'd2,
    FIN  = 2'd3
  } state_e;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
  } result_t;

  // Result reported for a zero divisor: saturated quotient, dividend low byte.
  function automatic result_t zero_div_result(input logic [VW-1:0] dividend_lo);
    result_t res;
    res.quotient    = DIV_ZERO_QUOTIENT;
    res.remainder   = dividend_lo;
    res.div_by_zero = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/div16by8_seq_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div16by8_seq_div_step
  import div16by8_seq_pkg::*;
(
  input  logic [VW-1:0] r_i,
  input  logic [DW-1:0] q_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW-1:0] r_o,
  output logic [DW-1:0] q_o
);

  logic [VW:0] t;
  logic        ge;

  // The 9-bit trial value never exceeds 2*divisor-1, so the kept remainder fits in VW bits.
  always_comb begin
    t   = {r_i, q_i[DW-1]};
    ge  = (t >= {1'b0, divisor_i});
    r_o = t[VW-1:0];
    if (ge) begin
      r_o = VW'(t - {1'b0, divisor_i});
    end
    q_o = {q_i[DW-2:0], ge};
  end

endmodule

// File: rtl/div16by8_seq.sv
// Sequential unsigned 16/8 divider: one quotient bit per clock, start/done
// handshake, results held until the next completed operation.
module div16by8_seq
  import div16by8_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_e        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic [VW-1:0] divisor_q, divisor_d;
  logic [VW-1:0] r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  result_t       res_q, res_d;

  logic [VW-1:0] step_r;
  logic [DW-1:0] step_q;

  div16by8_seq_div_step u_step (
    .r_i       (r_q),
    .q_i       (q_q),
    .divisor_i (divisor_q),
    .r_o       (step_r),
    .q_o       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      r_q       <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      r_q       <= r_d;
      q_q       <= q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      res_q     <= res_d;
    end
  end

  // Next-state and datapath update; the quotient shift register also keeps the
  // dividend intact through ZDIV so its low byte can become the remainder.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    r_d       = r_q;
    q_d       = q_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    res_d     = res_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          divisor_d = divisor;
          q_d       = dividend;
          r_d       = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = (divisor == '0) ? ZDIV : RUN;
        end
      end
      RUN: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_t'(cnt_q + cnt_t'(1));
        if (cnt_q == LAST_STEP) begin
          state_d = FIN;
        end
      end
      // Held for two edges so a zero divisor completes three cycles after start.
      ZDIV: begin
        cnt_d = cnt_t'(cnt_q + cnt_t'(1));
        if (cnt_q == ZDIV_LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
        if (divisor_q == '0) begin
          res_d = zero_div_result(q_q[VW-1:0]);
        end else begin
          res_d.quotient    = q_q;
          res_d.remainder   = r_q;
          res_d.div_by_zero = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = res_q.quotient;
  assign remainder   = res_q.remainder;
  assign div_by_zero = res_q.div_by_zero;

endmodule
